// File: rtl/demux4_deser.sv
// rtl/demux4_deser.sv - 4-bit serial-to-parallel deserializer with ready/valid handshakes; DEMUX4_DESER_PARITY_EN adds an even-parity beat and parity_err
module demux4_deser #(
  parameter int LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       clear,
  output logic [3:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
`ifdef DEMUX4_DESER_PARITY_EN
  output logic       parity_err,
`endif
  output logic [1:0] slot
);

`ifdef DEMUX4_DESER_PARITY_EN
  // Four data beats followed by one parity beat per word.
  localparam int CW = 3;
`else
  localparam int CW = 2;
`endif
  localparam logic [CW-1:0] LAST_SLOT = (CW == 3) ? 3'd4 : 3'd3;
  localparam logic [CW-1:0] CNT_ONE   = 1;

  logic [CW-1:0] cnt;
  logic [3:0]    collect;
  logic [3:0]    collect_next;
  logic [1:0]    pos;
  logic          data_slot;
  logic          accept;
  logic          load;
  logic          consume;

  // The only stall: the word-completing beat cannot land while an unconsumed word is still held.
  assign in_ready = !((cnt == LAST_SLOT) && out_valid && !out_ready);

  // clear outranks any beat presented in the same cycle.
  assign accept  = in_valid && in_ready && !clear;
  assign load    = accept && (cnt == LAST_SLOT);
  assign consume = out_valid && out_ready;

`ifdef DEMUX4_DESER_PARITY_EN
  assign data_slot = (cnt != LAST_SLOT);
  assign slot      = (cnt == LAST_SLOT) ? 2'd0 : cnt[1:0];
`else
  assign data_slot = 1'b1;
  assign slot      = cnt;
`endif

  // Bit position for the current beat and the collect register including that beat's bit.
  always_comb begin
    pos          = (LSB_FIRST != 0) ? cnt[1:0] : (2'd3 - cnt[1:0]);
    collect_next = collect;
    if (accept && data_slot) begin
      collect_next[pos] = in_bit;
    end
  end

  // Slot counter and partial-word collection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      collect <= '0;
    end else if (clear) begin
      cnt     <= '0;
      collect <= '0;
    end else if (accept) begin
      if (load) begin
        cnt     <= '0;
        collect <= '0;
      end else begin
        cnt     <= cnt + CNT_ONE;
        collect <= collect_next;
      end
    end
  end

`ifdef DEMUX4_DESER_PARITY_EN
  // Output word, valid flag and parity check; a same-edge load wins over consume.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data   <= 4'b0000;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
    end else if (load) begin
      out_data   <= collect_next;
      out_valid  <= 1'b1;
      parity_err <= (^collect_next) ^ in_bit;
    end else if (consume) begin
      out_valid  <= 1'b0;
    end
  end
`else
  // Output word and valid flag; a same-edge load wins over consume.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= 4'b0000;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= collect_next;
      out_valid <= 1'b1;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_demux4_deser.sv
// tb/tb_demux4_deser.sv - randomized bench for demux4_deser against a bit-list model, both bit orders
module tb_demux4_deser;

`ifdef DEMUX4_DESER_PARITY_EN
  localparam int BEATS = 5;
`else
  localparam int BEATS = 4;
`endif

  logic       clk;
  logic       reset_n;
  logic       in_bit;
  logic       in_valid;
  logic       clear;
  logic       out_ready;
  logic       in_ready1, in_ready0;
  logic       out_valid1, out_valid0;
  logic [3:0] out_data1, out_data0;
  logic [1:0] slot1, slot0;
`ifdef DEMUX4_DESER_PARITY_EN
  logic       pe1, pe0;
`endif

  demux4_deser #(.LSB_FIRST(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready1), .clear(clear), .out_data(out_data1),
    .out_valid(out_valid1), .out_ready(out_ready),
`ifdef DEMUX4_DESER_PARITY_EN
    .parity_err(pe1),
`endif
    .slot(slot1)
  );

  demux4_deser #(.LSB_FIRST(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready0), .clear(clear), .out_data(out_data0),
    .out_valid(out_valid0), .out_ready(out_ready),
`ifdef DEMUX4_DESER_PARITY_EN
    .parity_err(pe0),
`endif
    .slot(slot0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  // Model: list of bits accepted so far in the current word plus the held output word.
  int       m_bits [5];
  int       m_n;
  bit       m_ov;
  bit [3:0] m_d1, m_d0;
  bit       m_pe;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_ov = 0; m_d1 = 0; m_d0 = 0; m_pe = 0;
  endtask

  task automatic model_step();
    bit rdy, consume, load;
    if (!reset_n) begin
      model_reset();
      return;
    end
    rdy     = !(m_n == BEATS - 1 && m_ov && !out_ready);
    consume = m_ov && out_ready;
    load    = 0;
    if (clear) begin
      m_n = 0;
    end else if (in_valid && rdy) begin
      m_bits[m_n] = int'(in_bit);
      m_n++;
      if (m_n == BEATS) begin
        load = 1;
        m_n  = 0;
        m_pe = 0;
        for (int i = 0; i < 4; i++) begin
          m_d1[i]     = m_bits[i][0];
          m_d0[3 - i] = m_bits[i][0];
        end
        for (int i = 0; i < BEATS; i++) m_pe = m_pe ^ m_bits[i][0];
      end
    end
    if (load) m_ov = 1;
    else if (consume) m_ov = 0;
  endtask

  // Every-cycle comparison of both DUTs against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("in_ready1", in_ready1, !(m_n == BEATS - 1 && m_ov && !out_ready));
        chk("in_ready0", in_ready0, !(m_n == BEATS - 1 && m_ov && !out_ready));
        chk("out_valid1", out_valid1, m_ov);
        chk("out_valid0", out_valid0, m_ov);
        chk("slot1", slot1, (m_n >= 4) ? 0 : m_n);
        chk("slot0", slot0, (m_n >= 4) ? 0 : m_n);
        if (m_ov) begin
          chk("out_data1", out_data1, m_d1);
          chk("out_data0", out_data0, m_d0);
`ifdef DEMUX4_DESER_PARITY_EN
          chk("parity_err1", pe1, m_pe);
          chk("parity_err0", pe0, m_pe);
`endif
        end
      end
    end
  end

  task automatic drive(input logic v, input logic b, input logic r, input logic c);
    in_valid = v; in_bit = b; out_ready = r; clear = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  // s[0] is the first bit on the wire; parity builds append an even-parity beat.
  task automatic send4(input logic [3:0] s, input logic r);
    for (int i = 0; i < 4; i++) drive(1'b1, s[i], r, 1'b0);
    if (BEATS == 5) drive(1'b1, ^s, r, 1'b0);
  endtask

  logic [3:0] s2;
  logic       last_bit;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0; clear = 1'b0;
    model_reset();
    #3;
    chk("reset_in_ready", in_ready1, 1);
    chk("reset_out_valid", out_valid1, 0);
    chk("reset_slot", slot1, 0);
    chk("reset_out_data", out_data1, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("in_ready_during_reset", in_ready1, 1);
    reset_n = 1'b1;
    chk_en  = 1;

    // 1,0,1,1 with out_ready high: valid for exactly one cycle
    send4(4'b1101, 1'b1);
    chk("w1_valid", out_valid1, 1);
    chk("w1_data_lsb", out_data1, 4'b1101);
    chk("w1_data_msb", out_data0, 4'b1011);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("w1_valid_drop", out_valid1, 0);

    // 1,0,0,0
    send4(4'b0001, 1'b1);
    chk("w2_data_msb", out_data0, 4'b1000);
    chk("w2_data_lsb", out_data1, 4'b0001);
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    // Back-pressure: held word, stall at the completing beat, same-edge reload
    send4(4'b0110, 1'b0);
    s2 = 4'b0111;
    for (int i = 0; i < BEATS - 1; i++) drive(1'b1, (i < 4) ? s2[i] : ^s2, 1'b0, 1'b0);
    last_bit = (BEATS == 5) ? ^s2 : s2[3];
    in_valid = 1'b1; in_bit = last_bit; out_ready = 1'b0; clear = 1'b0;
    #1;
    chk("stall_in_ready", in_ready1, 0);
    chk("stall_slot", slot1, (BEATS == 4) ? 3 : 0);
    drive(1'b1, last_bit, 1'b0, 1'b0);
    drive(1'b1, last_bit, 1'b0, 1'b0);
    chk("hold_data", out_data1, 4'b0110);
    chk("hold_valid", out_valid1, 1);
    drive(1'b1, last_bit, 1'b1, 1'b0);
    chk("reload_valid", out_valid1, 1);
    chk("reload_data", out_data1, 4'b0111);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("reload_drop", out_valid1, 0);

    // Clear with an in-flight beat
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clear_slot", slot1, 0);
    send4(4'b1010, 1'b1);
    chk("post_clear_lsb", out_data1, 4'b1010);
    chk("post_clear_msb", out_data0, 4'b0101);
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset between edges, mid-word, with a held word
    send4(4'b0011, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid1, 0);
    chk("async_slot", slot1, 0);
    chk("async_out_data", out_data1, 0);
    chk("async_in_ready", in_ready1, 1);
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("first_beat_slot", slot1, 1);
    for (int i = 0; i < BEATS - 1; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("after_reset_word", out_data1, 4'b0001);
    drive(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef DEMUX4_DESER_PARITY_EN
    drive(1'b1, 1'b1, 1'b1, 1'b0); drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0); drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("parity_ok", pe1, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b0); drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0); drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("parity_bad", pe1, 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      drive(($urandom % 4) != 0, $urandom % 2, ($urandom % 3) != 0, ($urandom % 16) == 0);
    end

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
